// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the CPU run controller.
package cpu_ctrl_pkg;

  localparam int                 INSTR_W      = 16;
  localparam int                 ADDR_W       = 8;
  localparam logic [INSTR_W-1:0] HALT_WORD    = 16'hE000;
  localparam int                 BYTE_TIMEOUT = 1_000_000;
  localparam int                 SYNC_STAGES  = 2;
  localparam int                 WDT_CYCLES   = 2**24;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HI,
    S_LO,
    S_READY,
    S_RUN,
    S_STEP,
    S_HALT
  } state_t;

endpackage

// File: rtl/cpu_run_ctrl_btn_sync_edge.sv
// Multi-flop synchronizer for an asynchronous level input, plus a one-cycle
// pulse on its synchronized rising edge.
module btn_sync_edge #(
  parameter int STAGES = cpu_ctrl_pkg::SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [STAGES-1:0] chain_q;
  logic              q_d;

  // Shift the async input through the chain and keep one delayed copy for edge detect.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
      q_d     <= 1'b0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d};
      q_d     <= chain_q[STAGES-1];
    end
  end

  assign q    = chain_q[STAGES-1];
  assign rise = q & ~q_d;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: assembles UART byte pairs into instruction words, writes them
// into imem from address 1, hands imem to the CPU once loaded and gates CPU
// execution in free-run / single-step modes.
// Optional feature macro: RUN_CTRL_WATCHDOG_EN (run watchdog forcing S_HALT).
module cpu_run_ctrl #(
  parameter int          ADDR_W       = cpu_ctrl_pkg::ADDR_W,
  parameter logic [15:0] HALT_WORD    = cpu_ctrl_pkg::HALT_WORD,
  parameter int          BYTE_TIMEOUT = cpu_ctrl_pkg::BYTE_TIMEOUT,
  parameter int          SYNC_STAGES  = cpu_ctrl_pkg::SYNC_STAGES
`ifdef RUN_CTRL_WATCHDOG_EN
  , parameter int        WDT_CYCLES   = cpu_ctrl_pkg::WDT_CYCLES
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  input  logic              i_start_cpu,
  input  logic              i_step_mode,
  input  logic              i_next_instr,
  input  logic              i_cpu_instr_done,
  input  logic              i_cpu_halt,
  output logic              o_imem_sel,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [15:0]       o_imem_wdata,
  output logic [ADDR_W-1:0] o_max_addr_instr,
  output logic              o_load_done,
  output logic              o_cpu_en,
  output logic              o_cpu_rst_n,
  output logic              o_led_load,
  output logic              o_led_ready,
  output logic              o_led_halt
);

  import cpu_ctrl_pkg::*;

  localparam int TMR_W = $clog2(BYTE_TIMEOUT + 1);

  state_t             state_q, state_d;
  logic [7:0]         hi_q;
  logic [TMR_W-1:0]   timer_q;
  logic               last_q;
  logic               step_active_q;
  logic [INSTR_W-1:0] word;
  logic               latch_hi, wr_go, wr_last;
  logic               start_lvl, start_rise, step_lvl, step_rise, next_lvl, next_rise;
  logic               wdt_expire, wdt_err;
  logic               loaded;
  logic               unused_sync;

  btn_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_start (
    .clk(clk), .rst_n(rst_n), .d(i_start_cpu),  .q(start_lvl), .rise(start_rise)
  );
  btn_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_step (
    .clk(clk), .rst_n(rst_n), .d(i_step_mode),  .q(step_lvl),  .rise(step_rise)
  );
  btn_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_next (
    .clk(clk), .rst_n(rst_n), .d(i_next_instr), .q(next_lvl),  .rise(next_rise)
  );

  assign unused_sync = step_rise ^ next_lvl;
  assign word        = {hi_q, i_rx_data};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode and one-cycle datapath events.
  // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    latch_hi = 1'b0;
    wr_go    = 1'b0;
    wr_last  = 1'b0;
    unique case (state_q)
      S_IDLE, S_HI: begin
        if (i_rx_valid) begin
          latch_hi = 1'b1;
          state_d  = S_LO;
        end
      end
      S_LO: begin
        if (i_rx_valid) begin
          wr_go   = 1'b1;
          // A full address space ends the load just like the HALT word does.
          wr_last = (word == HALT_WORD) || (o_imem_addr == '1);
          state_d = wr_last ? S_READY : S_HI;
        end else if (timer_q == TMR_W'(BYTE_TIMEOUT)) begin
          state_d = (o_imem_addr == ADDR_W'(1)) ? S_IDLE : S_HI;
        end
      end
      S_READY: begin
        if (start_rise) state_d = step_lvl ? S_STEP : S_RUN;
      end
      S_RUN: begin
        if (i_cpu_halt)                     state_d = S_HALT;
        else if (wdt_expire)                state_d = S_HALT;
        else if (!start_lvl)                state_d = S_READY;
        else if (step_lvl && i_cpu_instr_done) state_d = S_STEP;
      end
      S_STEP: begin
        if (i_cpu_halt)     state_d = S_HALT;
        else if (!step_lvl) state_d = S_RUN;
      end
      S_HALT: begin
        if (i_rx_valid) begin
          latch_hi = 1'b1;
          state_d  = S_LO;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Loader datapath: hi byte, write strobe/data, address and last-address bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q             <= '0;
      o_imem_we        <= 1'b0;
      o_imem_wdata     <= '0;
      o_imem_addr      <= ADDR_W'(1);
      o_max_addr_instr <= '0;
      last_q           <= 1'b0;
    end else begin
      o_imem_we <= wr_go;
      last_q    <= wr_last;
      if (latch_hi) hi_q <= i_rx_data;
      if (wr_go)    o_imem_wdata <= word;
      // The address advances during the write cycle itself, so the write sees the old value.
      if (state_q == S_HALT && i_rx_valid) begin
        o_imem_addr <= ADDR_W'(1);
      end else if (o_imem_we) begin
        if (last_q) begin
          o_max_addr_instr <= o_imem_addr;
          o_imem_addr      <= ADDR_W'(1);
        end else begin
          o_imem_addr <= o_imem_addr + ADDR_W'(1);
        end
      end
    end
  end

  // Inter-byte timer: runs only while waiting for a lo byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                timer_q <= '0;
    else if (state_q == S_LO && state_d == S_LO) timer_q <= timer_q + TMR_W'(1);
    else                                       timer_q <= '0;
  end

  // Single-step permission: set by a button edge, cleared at retire unless a new edge arrives with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_active_q <= 1'b0;
    end else if (state_q == S_STEP && state_d == S_STEP) begin
      if (i_cpu_instr_done && step_active_q) step_active_q <= next_rise;
      else if (next_rise)                    step_active_q <= 1'b1;
    end else begin
      step_active_q <= 1'b0;
    end
  end

`ifdef RUN_CTRL_WATCHDOG_EN
  localparam int WDT_W = $clog2(WDT_CYCLES);
  logic [WDT_W-1:0] wdt_q;
  logic             wdt_err_q;

  // Watchdog counts free-run cycles; the error flag stays until the next reload starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdt_q     <= '0;
      wdt_err_q <= 1'b0;
    end else begin
      wdt_q <= (state_q == S_RUN) ? wdt_q + WDT_W'(1) : '0;
      if (state_q == S_HALT && latch_hi)
        wdt_err_q <= 1'b0;
      else if (state_q == S_RUN && wdt_expire && !i_cpu_halt)
        wdt_err_q <= 1'b1;
    end
  end

  assign wdt_expire = (state_q == S_RUN) && (wdt_q == WDT_W'(WDT_CYCLES - 1));
  assign wdt_err    = wdt_err_q;
`else
  assign wdt_expire = 1'b0;
  assign wdt_err    = 1'b0;
`endif

  assign loaded = (state_q == S_READY) || (state_q == S_RUN) ||
                  (state_q == S_STEP)  || (state_q == S_HALT);

  // The final write lands in the first loaded cycle, so the CPU takes imem only after it.
  assign o_imem_sel  = loaded && !o_imem_we;
  assign o_load_done = loaded;
  assign o_cpu_rst_n = loaded;
  assign o_cpu_en    = (state_q == S_RUN) || (state_q == S_STEP && step_active_q);
  assign o_led_load  = (state_q == S_HI) || (state_q == S_LO) || wdt_err;
  assign o_led_ready = (state_q == S_READY);
  assign o_led_halt  = (state_q == S_HALT);

endmodule
